ts_sampler: RTL and testbench

Dual-channel temperature sensor front end that produces the two 8-bit readings (`ts1`, `ts2`) the hysteresis comparator consumes. It periodically runs one serial read frame against two sensors that share chip-select and serial clock. Each sensor returns its reading on its own data line. The block publishes both readings with a one-cycle valid strobe and flags a disconnected sensor instead of forwarding a bogus value.

---
 rtl/ts_sampler_if.sv | 27 ++
 rtl/ts_sampler.sv | 122 ++++++++++++
 tb/tb_ts_sampler.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/ts_sampler_if.sv
// Purpose : serial sensor bus plus published readings of the ts_sampler block.
// Latency : none, this file holds wiring only.
// Backpressure: none. The valid strobe is a one-cycle pulse and has no ready.
// Ports : miso1/miso2 carry sensor data into the sampler. sclk and cs_n drive the sensors.
//         ts1/ts2/err/valid/busy carry the published results.
//         master = sampler side, slave = sensors / consumer side.
interface ts_sampler_if;
   logic       miso1;
   logic       miso2;
   logic       sclk;
   logic       cs_n;
   logic [7:0] ts1;
   logic [7:0] ts2;
   logic       valid;
   logic [1:0] err;
   logic       busy;

   modport master (
      input  miso1, miso2,
      output sclk, cs_n, ts1, ts2, valid, err, busy
   );

   modport slave (
      output miso1, miso2,
      input  sclk, cs_n, ts1, ts2, valid, err, busy
   );
endinterface

// File: rtl/ts_sampler.sv
// Purpose : reads two serial temperature sensors that share cs_n and sclk.
//           The block publishes 8-bit readings ts1/ts2 and flags absent sensors (byte 8'hFF).
// Latency : a frame runs 1 + 16*CLK_DIV cycles from ASSERT entry to DONE entry.
//           valid repeats every SAMPLE_PERIOD + 2 + 16*CLK_DIV cycles.
// Backpressure: none. valid is a one-cycle strobe, and ts/err hold until the next DONE.
// Ports : clk, rst (synchronous, active-high), and bus (ts_sampler_if.master).
//         bus holds miso1/miso2 in, and sclk/cs_n/ts1/ts2/valid/err/busy out. All outputs are registered.
module ts_sampler #(
   parameter int CLK_DIV       = 4,
   parameter int SAMPLE_PERIOD = 1000
) (
   input  logic          clk,
   input  logic          rst,
   ts_sampler_if.master  bus
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_ASSERT = 2'd1;
   localparam logic [1:0] S_SHIFT  = 2'd2;
   localparam logic [1:0] S_DONE   = 2'd3;

   localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int WW = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
   localparam logic [DW-1:0] DIV_LAST  = DW'(CLK_DIV - 1);
   localparam logic [WW-1:0] WAIT_LOAD = WW'(SAMPLE_PERIOD - 1);

   logic [1:0]    state;
   logic [WW-1:0] wait_cnt;
   logic [DW-1:0] div_cnt;
   logic [2:0]    bit_cnt;
   logic [7:0]    sh1;
   logic [7:0]    sh2;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         wait_cnt  <= '0;
         div_cnt   <= '0;
         bit_cnt   <= 3'd0;
         sh1       <= 8'h00;
         sh2       <= 8'h00;
         bus.sclk  <= 1'b0;
         bus.cs_n  <= 1'b1;
         bus.ts1   <= 8'h00;
         bus.ts2   <= 8'h00;
         bus.valid <= 1'b0;
         bus.err   <= 2'b00;
         bus.busy  <= 1'b0;
      end else begin
         // valid is set only on the edge that enters DONE. It therefore lasts exactly one cycle.
         bus.valid <= 1'b0;
         case (state)
            S_IDLE: begin
               bus.cs_n <= 1'b1;
               bus.sclk <= 1'b0;
               if (wait_cnt == '0) begin
                  state    <= S_ASSERT;
                  bus.cs_n <= 1'b0;
                  bus.busy <= 1'b1;
               end else begin
                  wait_cnt <= wait_cnt - 1'b1;
               end
            end

            S_ASSERT: begin
               // This is the one-cycle setup with cs_n low before the first low phase.
               state   <= S_SHIFT;
               div_cnt <= '0;
               bit_cnt <= 3'd0;
            end

            S_SHIFT: begin
               if (div_cnt == DIV_LAST) begin
                  div_cnt <= '0;
                  // sclk doubles as the phase flag: low = first half of the bit, high = second half.
                  if (!bus.sclk) begin
                     bus.sclk <= 1'b1;
                     sh1      <= {sh1[6:0], bus.miso1};
                     sh2      <= {sh2[6:0], bus.miso2};
                  end else begin
                     bus.sclk <= 1'b0;
                     if (bit_cnt == 3'd7) begin
                        // The readings are published on the DONE-entry edge.
                        // This makes them visible in the same cycle as valid.
                        state     <= S_DONE;
                        bus.cs_n  <= 1'b1;
                        bus.valid <= 1'b1;
                        if (sh1 == 8'hFF) begin
                           bus.err[0] <= 1'b1;
                        end else begin
                           bus.ts1    <= sh1;
                           bus.err[0] <= 1'b0;
                        end
                        if (sh2 == 8'hFF) begin
                           bus.err[1] <= 1'b1;
                        end else begin
                           bus.ts2    <= sh2;
                           bus.err[1] <= 1'b0;
                        end
                     end else begin
                        bit_cnt <= bit_cnt + 3'd1;
                     end
                  end
               end else begin
                  div_cnt <= div_cnt + 1'b1;
               end
            end

            S_DONE: begin
               state    <= S_IDLE;
               wait_cnt <= WAIT_LOAD;
               bus.busy <= 1'b0;
            end

            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ts_sampler.sv
// Purpose : testbench for ts_sampler.
//           dut_a uses the default timing and runs a table of frames, including a reset mid-frame.
//           dut_b runs with CLK_DIV=1 and receives random frames that are checked against a reading model.
// Latency : not applicable.
// Backpressure: not applicable.
// Ports : none. The bench owns the clock, the resets and two sensor models.
module tb_ts_sampler;

   localparam int CD_A = 4;
   localparam int SP_A = 1000;
   localparam int CD_B = 1;
   localparam int SP_B = 3;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_a = 1'b1;
   logic rst_b = 1'b1;

   ts_sampler_if bus_a ();
   ts_sampler_if bus_b ();

   ts_sampler #(.CLK_DIV(CD_A), .SAMPLE_PERIOD(SP_A)) dut_a (.clk(clk), .rst(rst_a), .bus(bus_a));
   ts_sampler #(.CLK_DIV(CD_B), .SAMPLE_PERIOD(SP_B)) dut_b (.clk(clk), .rst(rst_b), .bus(bus_b));

   // Each sensor model loads its byte when cs_n falls and presents the MSB first.
   // It moves to the next bit only on sclk falling edges.
   logic [7:0] byte_a1 = 8'h00, byte_a2 = 8'h00, byte_b1 = 8'h00, byte_b2 = 8'h00;
   logic [7:0] sh_a1 = 8'hFF, sh_a2 = 8'hFF, sh_b1 = 8'hFF, sh_b2 = 8'hFF;

   always @(negedge bus_a.cs_n) begin sh_a1 <= byte_a1; sh_a2 <= byte_a2; end
   always @(negedge bus_a.sclk) if (bus_a.cs_n === 1'b0) begin
      sh_a1 <= {sh_a1[6:0], 1'b1}; sh_a2 <= {sh_a2[6:0], 1'b1};
   end
   always @(negedge bus_b.cs_n) begin sh_b1 <= byte_b1; sh_b2 <= byte_b2; end
   always @(negedge bus_b.sclk) if (bus_b.cs_n === 1'b0) begin
      sh_b1 <= {sh_b1[6:0], 1'b1}; sh_b2 <= {sh_b2[6:0], 1'b1};
   end

   assign bus_a.miso1 = sh_a1[7];
   assign bus_a.miso2 = sh_a2[7];
   assign bus_b.miso1 = sh_b1[7];
   assign bus_b.miso2 = sh_b2[7];

   int ecount = 0;
   always @(posedge clk) ecount <= ecount + 1;

   int n_cmp  = 0;
   int n_fail = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic check_reset(input bit sel, input string tag);
      if (sel) begin
         check({tag, "_cs_n"},  32'(bus_b.cs_n),  32'd1);
         check({tag, "_sclk"},  32'(bus_b.sclk),  32'd0);
         check({tag, "_ts"},    32'({bus_b.ts1, bus_b.ts2}), 32'd0);
         check({tag, "_err"},   32'(bus_b.err),   32'd0);
         check({tag, "_valid"}, 32'(bus_b.valid), 32'd0);
         check({tag, "_busy"},  32'(bus_b.busy),  32'd0);
      end else begin
         check({tag, "_cs_n"},  32'(bus_a.cs_n),  32'd1);
         check({tag, "_sclk"},  32'(bus_a.sclk),  32'd0);
         check({tag, "_ts"},    32'({bus_a.ts1, bus_a.ts2}), 32'd0);
         check({tag, "_err"},   32'(bus_a.err),   32'd0);
         check({tag, "_valid"}, 32'(bus_a.valid), 32'd0);
         check({tag, "_busy"},  32'(bus_a.busy),  32'd0);
      end
   endtask

   // Samples at negedges until valid is seen, or until the budget runs out (vcyc = -1).
   // Cycle index c = ecount - base. Cycle 1 is the cycle after the first edge without reset.
   // While waiting, the task records sclk rises, busy cycles, the cs_n-low window,
   // and whether ts/err held steady.
   task automatic wait_valid(input bit sel, input int base, input int budget,
                             output int vcyc, output int rises, output int busy_n,
                             output int cs_first, output int cs_last, output bit stable);
      logic [17:0] snap, cur;
      logic        prev_sclk, s_sclk, s_cs_n, s_busy, s_valid;
      int          c;
      vcyc = -1; rises = 0; busy_n = 0; cs_first = -1; cs_last = -1; stable = 1'b1;
      prev_sclk = sel ? bus_b.sclk : bus_a.sclk;
      snap = sel ? {bus_b.ts1, bus_b.ts2, bus_b.err} : {bus_a.ts1, bus_a.ts2, bus_a.err};
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         c       = ecount - base;
         s_sclk  = sel ? bus_b.sclk  : bus_a.sclk;
         s_cs_n  = sel ? bus_b.cs_n  : bus_a.cs_n;
         s_busy  = sel ? bus_b.busy  : bus_a.busy;
         s_valid = sel ? bus_b.valid : bus_a.valid;
         cur = sel ? {bus_b.ts1, bus_b.ts2, bus_b.err} : {bus_a.ts1, bus_a.ts2, bus_a.err};
         if (s_sclk && !prev_sclk) rises++;
         prev_sclk = s_sclk;
         if (s_busy) busy_n++;
         if (!s_cs_n) begin
            if (cs_first < 0) cs_first = c;
            cs_last = c;
         end
         if (s_valid) begin
            vcyc = c;
            break;
         end
         if (cur !== snap) stable = 1'b0;
      end
   endtask

   typedef struct {
      logic [7:0] b1;
      logic [7:0] b2;
      logic [7:0] e1;
      logic [7:0] e2;
      logic [1:0] eerr;
   } vec_t;

   vec_t tbl [7];

   initial begin
      int base_a, base_b, vc, prev_vc, rises, busy_n, cs_first, cs_last;
      bit stable, hit, saw_valid;
      logic [7:0] m1, m2, r1, r2;
      logic [1:0] merr;
      int nr;
      logic ps;

      // Each row gives the sensor bytes for one frame and the expected published state afterwards.
      tbl[0] = '{8'h5A, 8'hC3, 8'h5A, 8'hC3, 2'b00};
      tbl[1] = '{8'h20, 8'h30, 8'h20, 8'h30, 2'b00};
      tbl[2] = '{8'hFF, 8'h31, 8'h20, 8'h31, 2'b01};
      tbl[3] = '{8'h21, 8'h31, 8'h21, 8'h31, 2'b00};
      tbl[4] = '{8'h00, 8'hFE, 8'h00, 8'hFE, 2'b00};
      tbl[5] = '{8'hFF, 8'hFF, 8'h00, 8'hFE, 2'b11};
      tbl[6] = '{8'h12, 8'hFF, 8'h12, 8'hFE, 2'b10};

      repeat (3) @(negedge clk);
      check_reset(1'b0, "rst_a");
      check_reset(1'b1, "rst_b");

      // ---------------- dut_a: table of consecutive frames ----------------
      byte_a1 = tbl[0].b1;
      byte_a2 = tbl[0].b2;
      rst_a   = 1'b0;
      base_a  = ecount;
      prev_vc = 0;
      for (int i = 0; i < 7; i++) begin
         byte_a1 = tbl[i].b1;
         byte_a2 = tbl[i].b2;
         wait_valid(1'b0, base_a, 2 * (SP_A + 2 + 16 * CD_A), vc, rises, busy_n, cs_first, cs_last, stable);
         check($sformatf("tbl%0d_ts1", i), 32'(bus_a.ts1), 32'(tbl[i].e1));
         check($sformatf("tbl%0d_ts2", i), 32'(bus_a.ts2), 32'(tbl[i].e2));
         check($sformatf("tbl%0d_err", i), 32'(bus_a.err), 32'(tbl[i].eerr));
         check($sformatf("tbl%0d_sclk_rises", i), 32'(rises), 32'd8);
         check($sformatf("tbl%0d_busy_cycles", i), 32'(busy_n), 32'(2 + 16 * CD_A));
         check($sformatf("tbl%0d_stable", i), 32'(stable), 32'd1);
         if (i == 0) begin
            check("first_valid_cycle", 32'(vc), 32'(2 + 16 * CD_A));
            check("first_cs_low_start", 32'(cs_first), 32'd1);
            check("first_cs_low_end", 32'(cs_last), 32'(1 + 16 * CD_A));
         end else begin
            check($sformatf("tbl%0d_valid_spacing", i), 32'(vc - prev_vc), 32'(SP_A + 2 + 16 * CD_A));
         end
         prev_vc = vc;
      end

      // ---------------- dut_a: reset during the 4th sclk high phase ----------------
      byte_a1 = 8'h44;
      byte_a2 = 8'h55;
      nr = 0; hit = 1'b0; saw_valid = 1'b0;
      ps = bus_a.sclk;
      for (int i = 0; i < 2 * (SP_A + 2 + 16 * CD_A); i++) begin
         @(negedge clk);
         if (bus_a.valid) saw_valid = 1'b1;
         if (bus_a.sclk && !ps) nr++;
         ps = bus_a.sclk;
         if (nr == 4) begin
            hit = 1'b1;
            break;
         end
      end
      check("midrst_reached", 32'(hit), 32'd1);
      check("midrst_no_valid_before", 32'(saw_valid), 32'd0);
      rst_a = 1'b1;
      @(negedge clk);
      check_reset(1'b0, "midrst");
      rst_a  = 1'b0;
      base_a = ecount;
      wait_valid(1'b0, base_a, 2 * (SP_A + 2 + 16 * CD_A), vc, rises, busy_n, cs_first, cs_last, stable);
      check("midrst_valid_cycle", 32'(vc), 32'(2 + 16 * CD_A));
      check("midrst_ts1", 32'(bus_a.ts1), 32'h44);
      check("midrst_ts2", 32'(bus_a.ts2), 32'h55);
      check("midrst_err", 32'(bus_a.err), 32'd0);
      check("midrst_sclk_rises", 32'(rises), 32'd8);
      rst_a = 1'b1;

      // ---------------- dut_b: CLK_DIV=1 bit-order frame, then random frames ----------------
      byte_b1 = 8'h81;
      byte_b2 = 8'h7E;
      rst_b   = 1'b0;
      base_b  = ecount;
      wait_valid(1'b1, base_b, 200, vc, rises, busy_n, cs_first, cs_last, stable);
      check("div1_valid_cycle", 32'(vc), 32'(2 + 16 * CD_B));
      check("div1_ts1", 32'(bus_b.ts1), 32'h81);
      check("div1_ts2", 32'(bus_b.ts2), 32'h7E);
      check("div1_err", 32'(bus_b.err), 32'd0);
      check("div1_sclk_rises", 32'(rises), 32'd8);
      check("div1_cs_low_span", 32'(cs_last - cs_first + 1), 32'(1 + 16 * CD_B));

      // Reading model: a byte of 8'hFF means the sensor is absent, so the previous reading is kept
      // and the fault flag is set. Any other byte is accepted and clears the flag.
      m1 = 8'h81; m2 = 8'h7E; merr = 2'b00;
      prev_vc = vc;
      for (int k = 0; k < 40; k++) begin
         r1 = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom_range(0, 255));
         r2 = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom_range(0, 255));
         byte_b1 = r1;
         byte_b2 = r2;
         wait_valid(1'b1, base_b, 200, vc, rises, busy_n, cs_first, cs_last, stable);
         if (r1 == 8'hFF) merr[0] = 1'b1; else begin m1 = r1; merr[0] = 1'b0; end
         if (r2 == 8'hFF) merr[1] = 1'b1; else begin m2 = r2; merr[1] = 1'b0; end
         check($sformatf("rnd%0d_ts1", k), 32'(bus_b.ts1), 32'(m1));
         check($sformatf("rnd%0d_ts2", k), 32'(bus_b.ts2), 32'(m2));
         check($sformatf("rnd%0d_err", k), 32'(bus_b.err), 32'(merr));
         check($sformatf("rnd%0d_spacing", k), 32'(vc - prev_vc), 32'(SP_B + 2 + 16 * CD_B));
         check($sformatf("rnd%0d_stable", k), 32'(stable), 32'd1);
         prev_vc = vc;
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
